// File: rtl/mima_pkg.sv
// Shared types for the instruction fetch unit.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one prefetch FIFO entry, instruction word tagged with its PC
//   ifu_state_t      : fetch control state (RUN = normal, FLUSH = discarding stale responses)
package mima_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ifu_state_t;

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// sync_fifo: small circular FIFO whose head is read straight out of the
// storage registers, so a pushed entry becomes visible on the cycle after
// the push.
//   clk, rst        : clock, asynchronous active-low reset (control state only)
//   flush           : empties the FIFO; overrides push and pop in the same cycle
//   push, push_data : write one entry (allowed while full if pop is also asserted)
//   pop             : consume the head entry (ignored while empty)
//   head_valid      : FIFO not empty
//   head_data       : oldest entry
//   count           : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter type  ENTRY_T = logic [31:0],
  parameter int   DEPTH   = 4,
  localparam int  PTR_W   = $clog2(DEPTH),
  localparam int  CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  ENTRY_T           push_data,
  input  logic             pop,
  output logic             head_valid,
  output ENTRY_T           head_data,
  output logic [CNT_W-1:0] count
);

  ENTRY_T           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher feeding the core.
// Issues word fetches over a valid/ready request channel, buffers the
// in-order responses with their PCs in a prefetch FIFO, and presents one
// instruction per cycle. A redirect flushes the FIFO and arranges for every
// response already owed by memory to be discarded.
//   clk, rst                      : clock, asynchronous active-low reset
//   mem_req_valid/ready/addr      : fetch request channel (held until accepted)
//   mem_rsp_valid/data            : in-order response words, always accepted
//   instr_valid/instr/instr_pc    : FIFO head presented to the core
//   instr_ready                   : core consumes the head this cycle
//   stall                         : no instruction available
//   redirect, redirect_pc         : control-flow change to a new PC
module ifu_prefetch
  import mima_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;

  ifu_state_t       state;
  ifu_state_t       state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      push_pc;
  logic [31:0]      redirect_target;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_cnt_nxt;
  logic [CNT_W-1:0] fifo_count;
  logic             req_stale;
  logic             req_stale_nxt;
  logic             accept;
  logic             credit_ok;
  logic             raise;
  logic             drop_rsp;
  logic             push;
  logic             pop;
  fetch_entry_t     head;

  assign accept          = mem_req_valid & mem_req_ready;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  // Buffered, in-flight and pending requests together never exceed the FIFO size.
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outstanding) + SUM_W'(mem_req_valid))
                     < SUM_W'(DEPTH);
  assign raise = (!mem_req_valid || accept) && !redirect && credit_ok;
  assign pop   = instr_valid & instr_ready & ~redirect;

  // Drop accounting. On redirect every response still owed becomes stale,
  // including one accepted this cycle; a pending request not yet accepted is
  // remembered in req_stale and joins drop_cnt once it is accepted.
  always_comb begin
    drop_cnt_nxt  = drop_cnt;
    req_stale_nxt = req_stale;
    if (redirect) begin
      drop_cnt_nxt  = outstanding - CNT_W'(mem_rsp_valid) + CNT_W'(accept);
      req_stale_nxt = mem_req_valid & ~mem_req_ready;
    end else begin
      if (drop_rsp) drop_cnt_nxt = drop_cnt_nxt - 1'b1;
      if (accept && req_stale) begin
        drop_cnt_nxt  = drop_cnt_nxt + 1'b1;
        req_stale_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (redirect && ((drop_cnt_nxt != '0) || req_stale_nxt)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (redirect) state_nxt = ((drop_cnt_nxt != '0) || req_stale_nxt) ? FLUSH : RUN;
        else if ((drop_cnt == '0) && !req_stale) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // drop_cnt is zero whenever the FSM is in RUN, so only FLUSH discards words.
  always_comb begin
    drop_rsp = 1'b0;
    if (state == FLUSH) drop_rsp = mem_rsp_valid && (drop_cnt != '0);
    push = mem_rsp_valid && !drop_rsp && !redirect;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_valid <= 1'b0;
      fetch_pc      <= RESET_PC;
      push_pc       <= RESET_PC;
      outstanding   <= '0;
      drop_cnt      <= '0;
      req_stale     <= 1'b0;
    end else begin
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(mem_rsp_valid);
      drop_cnt    <= drop_cnt_nxt;
      req_stale   <= req_stale_nxt;
      // fetch_pc always names the next address to be requested.
      if (raise) begin
        mem_req_valid <= 1'b1;
        fetch_pc      <= fetch_pc + 32'd4;
      end else if (accept) begin
        mem_req_valid <= 1'b0;
      end
      if (redirect) begin
        fetch_pc <= redirect_target;
        push_pc  <= redirect_target;
      end else if (push) begin
        push_pc <= push_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (raise) mem_req_addr <= fetch_pc;
  end

  sync_fifo #(
    .ENTRY_T (fetch_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_data  ('{pc: push_pc, instr: mem_rsp_data}),
    .pop        (pop),
    .head_valid (instr_valid),
    .head_data  (head),
    .count      (fifo_count)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;
  assign stall    = ~instr_valid;

  a_rsp_owed: assert property (@(posedge clk) disable iff (!rst)
    mem_rsp_valid |-> (outstanding != '0));
  a_out_bound: assert property (@(posedge clk) disable iff (!rst)
    outstanding <= CNT_W'(DEPTH));
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst)
    drop_cnt <= outstanding);

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  ifu_prefetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          tag;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          acc_cnt  = 0;
  int          pop_cnt  = 0;
  bit          req_tagged = 0;
  int          req_tag  = 0;
  logic [31:0] req_tag_addr = '0;
  logic [31:0] exp_req_addr = RESET_PC;
  bit          prev_redirect = 0;
  bit          last_req_valid = 0;
  bit          last_instr_valid = 0;
  logic [31:0] last_req_addr = '0;
  bit          cap_req = 0;
  bit          cap_pop = 0;
  logic [31:0] cap_req_addr = '0;
  logic [31:0] cap_pop_pc = '0;

  bit          ready_ctl  = 1;
  bit          rsp_en     = 1;
  bit          iready_ctl = 1;
  bit          redir_ctl  = 0;
  bit          redir_on_rsp = 0;
  logic [31:0] redir_pc_ctl = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  // One clock: drive inputs at the falling edge, score what the next rising
  // edge will do, then wait for that edge.
  task automatic cycle();
    mreq_t       m;
    logic [63:0] e;
    @(negedge clk);
    if (prev_redirect) check_eq("flush_invalid", 64'(instr_valid), 64'(0));
    check_eq("stall", 64'(stall), 64'(!instr_valid));
    last_req_valid   = mem_req_valid;
    last_req_addr    = mem_req_addr;
    last_instr_valid = instr_valid;

    if (rsp_en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word_of(mem_q[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    mem_req_ready = ready_ctl;
    instr_ready   = iready_ctl;
    redirect      = redir_ctl || (redir_on_rsp && mem_rsp_valid && instr_valid && instr_ready);
    if (redirect) redir_on_rsp = 0;
    redirect_pc   = redir_pc_ctl;
    redir_ctl     = 0;

    if (mem_req_valid && !req_tagged) begin
      req_tagged   = 1;
      req_tag      = epoch;
      req_tag_addr = mem_req_addr;
      check_eq("req_addr", 64'(mem_req_addr), 64'(exp_req_addr));
      exp_req_addr = exp_req_addr + 32'd4;
      if (cap_req) begin
        cap_req_addr = mem_req_addr;
        cap_req = 0;
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      check_eq("req_hold", 64'(mem_req_addr), 64'(req_tag_addr));
      m.addr = mem_req_addr;
      m.tag  = req_tag;
      m.due  = cyc + 1;
      mem_q.push_back(m);
      req_tagged = 0;
      acc_cnt++;
    end

    if (instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check_eq("pop_unexp", 64'(instr_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("pop", {instr_pc, instr}, e);
        pop_cnt++;
        if (cap_pop) begin
          cap_pop_pc = instr_pc;
          cap_pop = 0;
        end
      end
    end

    if (mem_rsp_valid) begin
      m = mem_q.pop_front();
      if (m.tag == epoch && !redirect) exp_q.push_back({m.addr, word_of(m.addr)});
    end

    if (redirect) begin
      exp_q.delete();
      epoch++;
      exp_req_addr = {redirect_pc[31:2], 2'b00};
      cap_req = 1;
      cap_pop = 1;
    end
    prev_redirect = redirect;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    #1;
    check_eq("rst_req_valid", 64'(mem_req_valid), 64'(0));
    check_eq("rst_instr_valid", 64'(instr_valid), 64'(0));
    check_eq("rst_stall", 64'(stall), 64'(1));
    mem_q.delete();
    exp_q.delete();
    req_tagged    = 0;
    epoch++;
    exp_req_addr  = RESET_PC;
    prev_redirect = 0;
    cap_req = 1;
    cap_pop = 1;
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int p0;
    logic [31:0] hold;
    mem_req_ready = 0;
    mem_rsp_valid = 0;
    mem_rsp_data  = '0;
    instr_ready   = 0;
    redirect      = 0;
    redirect_pc   = '0;

    // Basic streaming from reset.
    do_reset();
    ready_ctl = 1; rsp_en = 1; iready_ctl = 1;
    p0 = pop_cnt;
    repeat (12) cycle();
    check_eq("t1_first_pc", 64'(cap_pop_pc), 64'(RESET_PC));
    check_eq("t1_pops", 64'((pop_cnt - p0) >= 4), 64'(1));

    // Core stalled: credit limits issue to DEPTH requests.
    iready_ctl = 0;
    do_reset();
    n0 = acc_cnt;
    repeat (20) cycle();
    check_eq("t2_issued", 64'(acc_cnt - n0), 64'(4));
    check_eq("t2_req_idle", 64'(last_req_valid), 64'(0));
    check_eq("t2_full_valid", 64'(last_instr_valid), 64'(1));
    cap_req = 1;
    iready_ctl = 1;
    repeat (15) cycle();
    check_eq("t2_resume_addr", 64'(cap_req_addr), 64'(32'h10));
    check_eq("t2_first_pc", 64'(cap_pop_pc), 64'(RESET_PC));

    // Redirect with three responses owed.
    rsp_en = 0;
    for (int i = 0; i < 40 && mem_q.size() < 3; i++) begin
      ready_ctl = 1;
      cycle();
    end
    check_eq("t3_owed", 64'(mem_q.size()), 64'(3));
    ready_ctl = 0;
    redir_pc_ctl = 32'h0000_0103;
    redir_ctl = 1;
    cycle();
    ready_ctl = 1; rsp_en = 1;
    repeat (20) cycle();
    check_eq("t3_req_addr", 64'(cap_req_addr), 64'(32'h100));
    check_eq("t3_first_pc", 64'(cap_pop_pc), 64'(32'h100));

    // Redirect while a request waits for ready.
    ready_ctl = 0;
    for (int i = 0; i < 20 && !req_tagged; i++) cycle();
    check_eq("t4_pending", 64'(req_tagged), 64'(1));
    hold = req_tag_addr;
    redir_pc_ctl = 32'h0000_0200;
    redir_ctl = 1;
    cycle();
    repeat (3) cycle();
    check_eq("t4_hold_valid", 64'(last_req_valid), 64'(1));
    check_eq("t4_hold_addr", 64'(last_req_addr), 64'(hold));
    ready_ctl = 1;
    repeat (20) cycle();
    check_eq("t4_req_addr", 64'(cap_req_addr), 64'(32'h200));
    check_eq("t4_first_pc", 64'(cap_pop_pc), 64'(32'h200));

    // Redirect coinciding with a response and a pop.
    repeat (4) cycle();
    redir_pc_ctl = 32'h0000_0300;
    redir_on_rsp = 1;
    for (int i = 0; i < 30 && redir_on_rsp; i++) cycle();
    check_eq("t5_fired", 64'(redir_on_rsp), 64'(0));
    repeat (15) cycle();
    check_eq("t5_req_addr", 64'(cap_req_addr), 64'(32'h300));
    check_eq("t5_first_pc", 64'(cap_pop_pc), 64'(32'h300));

    // Reset mid-stream with two responses owed.
    rsp_en = 0;
    for (int i = 0; i < 40 && mem_q.size() < 2; i++) cycle();
    check_eq("t6_owed", 64'(mem_q.size()), 64'(2));
    do_reset();
    rsp_en = 1; ready_ctl = 1; iready_ctl = 1;
    repeat (15) cycle();
    check_eq("t6_req_addr", 64'(cap_req_addr), 64'(RESET_PC));
    check_eq("t6_first_pc", 64'(cap_pop_pc), 64'(RESET_PC));

    // PC wrap at the top of the address space, low redirect bits ignored.
    redir_pc_ctl = 32'hFFFF_FFFA;
    redir_ctl = 1;
    cycle();
    p0 = pop_cnt;
    repeat (15) cycle();
    check_eq("t7_first_pc", 64'(cap_pop_pc), 64'(32'hFFFF_FFF8));
    check_eq("t7_pops", 64'((pop_cnt - p0) >= 4), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
